mem_bus_ctrl: RTL

- Parametrised memory-bus controller between the CPU core's memory port (Read/write_mem, MAR, MDR) and a variable-latency RAM or peripheral.
- Replaces the fixed single-cycle memory assumption with a request/acknowledge handshake, so the control unit can stall on slow memory.
- Adds address-range checking and a registered read-data holding register.

---
 rtl/mem_bus_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: request/acknowledge controller between the core memory port and variable-latency memory.
// Optional ack timeout is enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_ctrl #(
    parameter int DATA_W      = 32,
    parameter int CORE_ADDR_W = 32,
    parameter int ADDR_W      = 9,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_rd_req,
    input  logic                   i_wr_req,
    input  logic [CORE_ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0]      i_wr_data,
    output logic [DATA_W-1:0]      o_rd_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic [ADDR_W-1:0]      o_mem_addr,
    output logic [DATA_W-1:0]      o_mem_wdata,
    output logic                   o_mem_re,
    output logic                   o_mem_we,
    input  logic [DATA_W-1:0]      i_mem_rdata,
    input  logic                   i_mem_ack
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("mem_bus_ctrl: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_is_wr;
    logic                r_err;
    logic [DATA_W-1:0]   r_rd_data;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_req;
    logic                w_bad;
    logic                w_start;
    logic                w_err_nxt;
    logic                w_capture;
    logic                w_timeout;

    assign w_req = i_rd_req | i_wr_req;
    assign w_bad = (i_rd_req & i_wr_req) | (|i_addr[CORE_ADDR_W-1:ADDR_W]);

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_wait;

    // r_wait holds the number of ACCESS cycles already spent without ack.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_start) begin
            r_wait <= '0;
        end else if (r_state == S_ACCESS && !i_mem_ack) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    assign w_timeout = (r_wait == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_err_nxt   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (i_mem_ack) begin
                    w_capture   = ~r_is_wr;
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_is_wr     <= 1'b0;
            r_err       <= 1'b0;
            r_rd_data   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_err <= w_err_nxt;
            if (w_start) begin
                r_is_wr     <= i_wr_req;
                r_mem_addr  <= i_addr[ADDR_W-1:0];
                r_mem_wdata <= i_wr_data;
            end
            if (w_capture) begin
                r_rd_data <= i_mem_rdata;
            end
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_busy      = (r_state == S_ACCESS);
    assign o_done      = (r_state == S_RESP);
    assign o_err       = r_err;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_re    = (r_state == S_ACCESS) & ~r_is_wr;
    assign o_mem_we    = (r_state == S_ACCESS) & r_is_wr;

endmodule
